// File: rtl/kernel_buffer_pkg.sv
// Shared types and sizing helpers for the ping-pong kernel weight/bias buffer.
package kernel_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BIAS,
    ST_WGT,
    ST_DONE
  } load_state_t;

  localparam int K_DEF = 3;
  localparam int KK    = K_DEF * K_DEF;

  function automatic int tap_count(input int k);
    return k * k;
  endfunction

  // Minimum 1 bit so degenerate depths still give a legal vector.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/kb_bank.sv
// One storage bank: weight RAM (one K*K tap vector per ci/co) plus bias RAM (one word per co).
module kb_bank import kernel_buffer_pkg::*; #(
  parameter int DW     = 16,
  parameter int NTAP   = 9,
  parameter int MAX_CI = 64,
  parameter int MAX_CO = 64,
  parameter int WAW    = addr_w(MAX_CI * MAX_CO),
  parameter int BAW    = addr_w(MAX_CO)
) (
  input  logic                 clk,
  input  logic                 wgt_we,
  input  logic [WAW-1:0]       wgt_waddr,
  input  logic [NTAP*DW-1:0]   wgt_wdata,
  input  logic                 bias_we,
  input  logic [BAW-1:0]       bias_waddr,
  input  logic [DW-1:0]        bias_wdata,
  input  logic                 rd_en,
  input  logic [WAW-1:0]       wgt_raddr,
  input  logic [BAW-1:0]       bias_raddr,
  output logic [NTAP*DW-1:0]   wgt_rdata,
  output logic [DW-1:0]        bias_rdata
);

  logic [NTAP*DW-1:0] wgt_mem  [MAX_CI*MAX_CO];
  logic [DW-1:0]      bias_mem [MAX_CO];

  // Read registers only move on a read, so the last result is held otherwise.
  always_ff @(posedge clk) begin
    if (wgt_we)  wgt_mem[wgt_waddr]   <= wgt_wdata;
    if (bias_we) bias_mem[bias_waddr] <= bias_wdata;
    if (rd_en) begin
      wgt_rdata  <= wgt_mem[wgt_raddr];
      bias_rdata <= bias_mem[bias_raddr];
    end
  end

endmodule

// File: rtl/kernel_buffer.sv
// Host-loadable ping-pong kernel buffer: shadow bank streamed in, active bank read with 1-cycle latency.
module kernel_buffer import kernel_buffer_pkg::*; #(
  parameter int DW     = 16,
  parameter int K      = 3,
  parameter int MAX_CI = 64,
  parameter int MAX_CO = 64,
  parameter int CIW    = $clog2(MAX_CI),
  parameter int COW    = $clog2(MAX_CO)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load_start,
  input  logic [CIW:0]       i_num_ci,
  input  logic [COW:0]       i_num_co,
  input  logic               i_ld_valid,
  input  logic [DW-1:0]      i_ld_data,
  output logic               o_ld_ready,
  output logic               o_load_done,
  input  logic               i_swap,
  output logic               o_active_valid,
  input  logic               i_rd_en,
  input  logic [CIW-1:0]     i_rd_ci,
  input  logic [COW-1:0]     i_rd_co,
  output logic [K*K*DW-1:0]  o_weight,
  output logic [DW-1:0]      o_bias,
  output logic               o_rd_valid,
  output logic               o_rd_err
);

  localparam int NTAP = tap_count(K);
  localparam int TW   = addr_w(NTAP);
  localparam int WAW  = addr_w(MAX_CI * MAX_CO);
  localparam int BAW  = addr_w(MAX_CO);

  load_state_t        state_q, state_d;
  logic               act, shadow;
  logic [1:0]         bank_valid;
  logic [CIW:0]       num_ci_ld, act_nci;
  logic [COW:0]       num_co_ld, act_nco;
  logic [CIW-1:0]     ci_q;
  logic [COW-1:0]     co_q;
  logic [TW-1:0]      tap_q;
  logic [NTAP*DW-1:0] asm_q, wgt_word;
  logic               ld_ready, load_done, start_go, bias_we, wgt_we, swap_go;
  logic               last_tap, last_ci, last_co, rd_oob;
  logic               vld_p0, err_p0, bank_p0;
  logic [NTAP*DW-1:0] wgt_rd  [2];
  logic [DW-1:0]      bias_rd [2];

  assign shadow   = ~act;
  assign last_tap = (tap_q == TW'(NTAP - 1));
  assign last_ci  = (({1'b0, ci_q} + (CIW+1)'(1)) == num_ci_ld);
  assign last_co  = (({1'b0, co_q} + (COW+1)'(1)) == num_co_ld);
  // Newest word enters at the top so tap 0 ends up in the LSBs after K*K shifts.
  assign wgt_word = {i_ld_data, asm_q[NTAP*DW-1:DW]};

  always_comb begin
    state_d   = state_q;
    ld_ready  = 1'b0;
    load_done = 1'b0;
    start_go  = 1'b0;
    bias_we   = 1'b0;
    wgt_we    = 1'b0;
    swap_go   = 1'b0;
    case (state_q)
      ST_IDLE: if (i_load_start) begin
        start_go = 1'b1;
        state_d  = ST_BIAS;
      end
      ST_BIAS: begin
        ld_ready = 1'b1;
        if (i_ld_valid) begin
          bias_we = 1'b1;
          state_d = ST_WGT;
        end
      end
      ST_WGT: begin
        ld_ready = 1'b1;
        if (i_ld_valid && last_tap) begin
          wgt_we = 1'b1;
          if (last_ci) state_d = last_co ? ST_DONE : ST_BIAS;
        end
      end
      ST_DONE: begin
        load_done = 1'b1;
        if (i_swap) begin
          swap_go = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      act        <= 1'b0;
      bank_valid <= 2'b00;
      act_nci    <= '0;
      act_nco    <= '0;
      num_ci_ld  <= '0;
      num_co_ld  <= '0;
      ci_q       <= '0;
      co_q       <= '0;
      tap_q      <= '0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        num_ci_ld          <= i_num_ci;
        num_co_ld          <= i_num_co;
        ci_q               <= '0;
        co_q               <= '0;
        tap_q              <= '0;
        bank_valid[shadow] <= 1'b0;
      end
      if (state_q == ST_WGT && i_ld_valid) begin
        if (last_tap) begin
          tap_q <= '0;
          if (last_ci) begin
            ci_q <= '0;
            co_q <= co_q + COW'(1);
          end else begin
            ci_q <= ci_q + CIW'(1);
          end
        end else begin
          tap_q <= tap_q + TW'(1);
        end
      end
      if (swap_go) begin
        act                <= shadow;
        bank_valid[shadow] <= 1'b1;
        act_nci            <= num_ci_ld;
        act_nco            <= num_co_ld;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (state_q == ST_WGT && i_ld_valid) asm_q <= wgt_word;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    kb_bank #(
      .DW(DW), .NTAP(NTAP), .MAX_CI(MAX_CI), .MAX_CO(MAX_CO), .WAW(WAW), .BAW(BAW)
    ) u_bank (
      .clk        (i_clk),
      .wgt_we     (wgt_we && (shadow == 1'(b))),
      .wgt_waddr  (WAW'(int'(ci_q) * MAX_CO + int'(co_q))),
      .wgt_wdata  (wgt_word),
      .bias_we    (bias_we && (shadow == 1'(b))),
      .bias_waddr (BAW'(co_q)),
      .bias_wdata (i_ld_data),
      .rd_en      (i_rd_en && (act == 1'(b))),
      .wgt_raddr  (WAW'(int'(i_rd_ci) * MAX_CO + int'(i_rd_co))),
      .bias_raddr (BAW'(i_rd_co)),
      .wgt_rdata  (wgt_rd[b]),
      .bias_rdata (bias_rd[b])
    );
  end

  assign rd_oob = !bank_valid[act] || ({1'b0, i_rd_ci} >= act_nci) || ({1'b0, i_rd_co} >= act_nco);

  // ---- stage p0: read request registered alongside the bank RAM lookup ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0  <= 1'b0;
      err_p0  <= 1'b1;
      bank_p0 <= 1'b0;
    end else begin
      vld_p0 <= i_rd_en;
      if (i_rd_en) begin
        err_p0  <= rd_oob;
        bank_p0 <= act;
      end
    end
  end

  assign o_ld_ready     = ld_ready;
  assign o_load_done    = load_done;
  assign o_active_valid = bank_valid[act];
  assign o_rd_valid     = vld_p0;
  assign o_rd_err       = vld_p0 && err_p0;
  assign o_weight       = err_p0 ? '0 : wgt_rd[bank_p0];
  assign o_bias         = err_p0 ? '0 : bias_rd[bank_p0];

endmodule

// File: doc/kernel_buffer.md
Name: kernel_buffer

Overview:
Parametrised, host-loadable successor to the fixed kernel ROM. It holds K*K weights per (ci,co) pair and one bias per co. Storage is ping-pong: two banks, so the host streams the next layer's kernels into the shadow bank while the conv datapath reads the active bank with a 1-cycle registered lookup. The block sits between the host load stream and the conv2d PE array.

Parameters:
DW, 16, weight/bias word width (fixed point)
K, 3, kernel side; K*K taps per (ci,co)
MAX_CI, 64, max input channels
MAX_CO, 64, max output channels
CIW, $clog2(MAX_CI), ci index width (derived)
COW, $clog2(MAX_CO), co index width (derived)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_load_start  in  1  pulse; begin loading shadow bank
i_num_ci  in  CIW+1  channel count for this load, 1..MAX_CI (sampled at start)
i_num_co  in  COW+1  co count for this load, 1..MAX_CO (sampled at start)
i_ld_valid  in  1  load word valid
i_ld_data  in  DW  load word
o_ld_ready  out  1  load word accepted when valid&ready
o_load_done  out  1  shadow bank fully loaded, awaiting swap
i_swap  in  1  pulse; make shadow bank active
o_active_valid  out  1  active bank holds a complete load
i_rd_en  in  1  read request
i_rd_ci  in  CIW  read ci index
i_rd_co  in  COW  read co index
o_weight  out  K*K*DW  taps, tap 0 in LSBs
o_bias  out  DW  bias for o_rd co
o_rd_valid  out  1  read data valid
o_rd_err  out  1  read out of range or active bank invalid

Behaviour:
- Reset: load FSM IDLE; active bank 0; both bank-valid flags 0; all outputs 0. Memory contents are not reset.
- Load FSM states: IDLE, BIAS, WGT, DONE.
- IDLE: o_ld_ready=0. On i_load_start, latch num_ci/num_co, clear counters and shadow valid flag, go to BIAS. i_load_start in any other state is ignored.
- Stream order, per co 0..num_co-1: one bias word, then for ci 0..num_ci-1, K*K taps with tap 0 first.
- BIAS: o_ld_ready=1. On a handshake, write the bias to shadow[co] and go to WGT.
- WGT: o_ld_ready=1. Each handshake shifts the word into the tap assembler. On tap==K*K-1, write the assembled vector to shadow[ci*MAX_CO+co] and clear tap.
  - ci wraps at num_ci, then co increments and the FSM returns to BIAS.
  - After the final tap of co=num_co-1, go to DONE.
- DONE: o_ld_ready=0, o_load_done=1.
- Swap: i_swap takes effect only in DONE. Active bank toggles, the new active valid flag is set to 1, and the FSM goes to IDLE.
  - i_swap outside DONE is ignored; there is no error.
  - Active num_ci/num_co are updated from the load's latched values.
- Reads: latency exactly 1 cycle, one read per cycle, no stall.
  - o_rd_valid = i_rd_en delayed 1.
  - Data comes from the bank that was active in the request cycle. A read coincident with a swap returns the old bank.
- Out of range (ci>=active num_ci, co>=active num_co, or active bank invalid): o_weight=0, o_bias=0, o_rd_err=1 with o_rd_valid=1.
- When o_rd_valid=0, o_weight/o_bias hold their last value and o_rd_err=0.
- i_rst mid-load: FSM returns to IDLE, partial shadow contents are discarded (valid=0), and the active bank invalidates to reset state.
- Loads never touch the active bank, so a read and a load in the same cycle never conflict.

Decomposition:
- Package kernel_buffer_pkg: load FSM state enum, tap-count constant KK=K*K, address-width helper functions.
- One sub-module, kb_bank: single-bank synchronous RAM pair (weight depth MAX_CI*MAX_CO × KK*DW; bias depth MAX_CO × DW), with 1 write port and 1 registered read port. It is instantiated twice.

Test Plan:
- Load num_ci=2, num_co=2, K=3: bias 0x0100, taps 1..9, then 10..18; bias 0x0200, taps 19..36; swap. Reading (ci=1,co=0) one cycle later gives weight taps 10..18 (tap0=10) and o_bias=0x0100, with o_rd_valid=1.
- Read (ci=2,co=0) after that load -> o_rd_err=1, o_weight=0, o_bias=0. A read before any swap after reset -> o_rd_err=1.
- Load a second set with all taps 0x7FFF while reading continuously from the active bank -> reads return the first set until the swap cycle. A read in the swap cycle is old data; the next read is 0x7FFF.
- Deassert i_ld_valid randomly mid-stream -> final contents are identical to the gap-free load, and o_load_done rises only after word 2*(1+2*9)=38.
- i_swap pulsed during WGT -> ignored; active bank and o_active_valid are unchanged. Assert i_rst at word 20 -> o_ld_ready=0, FSM IDLE, o_active_valid=0.
- i_load_start pulsed during BIAS/WGT -> ignored; the counters continue and the load finishes correctly.
